// File: rtl/fifo_rd_ctrl_if.sv
// Stream port of the FIFO read controller: valid/ready handshake carrying one data word.
// The controller drives the master side; the downstream sink uses the slave side.
interface fifo_rd_ctrl_if #(
   parameter int WIDTH = 16
) ();
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;

   modport master (output m_data, output m_valid, input  m_ready);
   modport slave  (input  m_data, input  m_valid, output m_ready);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry skid buffer.
// Define FIFO_RD_CTRL_STATS_EN to build rd_count, uf_count and err_underflow.
module fifo_rd_ctrl #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   fifo_rd_ctrl_if.master        m_if,
   output logic                  busy,
   output logic                  err_underflow,
   input  logic                  stats_clr,
   output logic [15:0]           rd_count,
   output logic [7:0]            uf_count
);

   if (FIFO_DEPTH < 2) begin : g_depth_check
      $error("fifo_rd_ctrl: FIFO_DEPTH must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e                state_q;
   logic                  busy_q;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
   logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
   logic                  pop;
   logic                  push;
   logic [2:0]            level;

   assign pop   = (occ_q != 2'd0) && m_if.m_ready;
   assign push  = inflight_q && !fifo_underflow;
   // Words already committed to the buffer once this cycle's pop is accounted for.
   assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

   assign fifo_rd_en   = (state_q == RUN) && !fifo_empty && (level < 3'd2);
   assign m_if.m_valid = (occ_q != 2'd0);
   assign m_if.m_data  = buf0_q;
   assign busy         = busy_q;

   // buf0 is always the head; buf1 only ever holds the second-oldest word.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      occ_d  = occ_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) buf0_d = fifo_data_out;
            else               buf1_d = fifo_data_out;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd2) begin
               buf0_d = buf1_q;
               buf1_d = fifo_data_out;
            end else begin
               buf0_d = fifo_data_out;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the buffer entries are reset too, so m_data reads 0 out of reset.
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_rd_en;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (enable) begin
               state_q <= RUN;
               busy_q  <= 1'b1;
            end
            RUN: if (!enable) state_q <= DRAIN;
            DRAIN: begin
               if (enable) begin
                  state_q <= RUN;
               end else if (!inflight_q && (occ_q == 2'd0)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_RD_CTRL_STATS_EN
   logic        uf_evt;
   logic [15:0] rd_count_q;
   logic [7:0]  uf_count_q;
   logic        err_q;

   assign uf_evt = inflight_q && fifo_underflow;

   // Clear takes priority over any increment landing in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count_q <= 16'd0;
         uf_count_q <= 8'd0;
         err_q      <= 1'b0;
      end else if (stats_clr) begin
         rd_count_q <= 16'd0;
         uf_count_q <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         if (pop) rd_count_q <= rd_count_q + 16'd1;
         if (uf_evt) begin
            err_q <= 1'b1;
            if (uf_count_q != 8'hFF) uf_count_q <= uf_count_q + 8'd1;
         end
      end
   end

   assign rd_count      = rd_count_q;
   assign uf_count      = uf_count_q;
   assign err_underflow = err_q;
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;
   assign rd_count         = 16'd0;
   assign uf_count         = 8'd0;
   assign err_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural source FIFO (data/underflow one cycle after read).
// Statistics expectations follow FIFO_RD_CTRL_STATS_EN.
module tb_fifo_rd_ctrl;

`ifdef FIFO_RD_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b0;
   logic        stats_clr = 1'b0;
   logic        fifo_empty;
   logic [15:0] fifo_data_out = 16'd0;
   logic        fifo_underflow = 1'b0;
   logic        fifo_rd_en;
   logic        busy;
   logic        err_underflow;
   logic [15:0] rd_count;
   logic [7:0]  uf_count;

   logic [15:0] mem [0:1023];
   int          wp = 0;
   int          rp = 0;
   logic        model_clr = 1'b0;
   logic        force_uf = 1'b0;

   int passed = 0;
   int total  = 0;

   fifo_rd_ctrl_if #(.WIDTH(16)) m_if ();

   fifo_rd_ctrl #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .fifo_empty     (fifo_empty),
      .fifo_data_out  (fifo_data_out),
      .fifo_underflow (fifo_underflow),
      .fifo_rd_en     (fifo_rd_en),
      .m_if           (m_if.master),
      .busy           (busy),
      .err_underflow  (err_underflow),
      .stats_clr      (stats_clr),
      .rd_count       (rd_count),
      .uf_count       (uf_count)
   );

   always #5 clk = ~clk;

   // Source FIFO model: one pop per fifo_rd_en cycle, result visible the next cycle.
   assign fifo_empty = (rp == wp);

   always @(posedge clk) begin
      if (model_clr) begin
         rp             <= 0;
         fifo_underflow <= 1'b0;
         fifo_data_out  <= 16'd0;
      end else begin
         fifo_underflow <= fifo_rd_en && (force_uf || (rp == wp));
         if (fifo_rd_en && (rp != wp)) begin
            fifo_data_out <= mem[rp];
            rp            <= rp + 1;
         end
      end
   end

   task automatic load_words(input logic [15:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         mem[wp] = first + 16'(i);
         wp      = wp + 1;
      end
   endtask

   // Leaves the bench at a falling edge with reset just released and all inputs idle.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; model_clr = 1'b1;
      enable = 1'b0; m_if.m_ready = 1'b0; stats_clr = 1'b0; force_uf = 1'b0;
      wp = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; model_clr = 1'b0;
   endtask

   task automatic test_reset();
      m_if.m_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); else passed++;
      total++; if (m_if.m_valid !== 1'b0) $display("FAIL reset_m_valid got %b exp 0", m_if.m_valid); else passed++;
      total++; if (m_if.m_data !== 16'h0) $display("FAIL reset_m_data got %h exp 0000", m_if.m_data); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
      total++; if (err_underflow !== 1'b0) $display("FAIL reset_err got %b exp 0", err_underflow); else passed++;
      total++; if (rd_count !== 16'd0) $display("FAIL reset_rd_count got %0d exp 0", rd_count); else passed++;
      total++; if (uf_count !== 8'd0) $display("FAIL reset_uf_count got %0d exp 0", uf_count); else passed++;
   endtask

   task automatic test_stream();
      logic exp_rd, exp_v;
      do_reset();
      load_words(16'h0001, 8);
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) @(negedge clk);
         enable = 1'b1; m_if.m_ready = 1'b1;
         #1;
         exp_rd = (c >= 1) && (c <= 8);
         exp_v  = (c >= 3) && (c <= 10);
         total++; if (fifo_rd_en !== exp_rd) $display("FAIL stream_rd_en c=%0d got %b exp %b", c, fifo_rd_en, exp_rd); else passed++;
         total++; if (m_if.m_valid !== exp_v) $display("FAIL stream_valid c=%0d got %b exp %b", c, m_if.m_valid, exp_v); else passed++;
         if (exp_v) begin
            total++; if (m_if.m_data !== 16'(c - 2)) $display("FAIL stream_data c=%0d got %h exp %h", c, m_if.m_data, 16'(c - 2)); else passed++;
         end
         if (c == 1) begin
            total++; if (busy !== 1'b1) $display("FAIL stream_busy got %b exp 1", busy); else passed++;
         end
      end
      total++; if (rd_count !== (STATS ? 16'd8 : 16'd0)) $display("FAIL stream_rd_count got %0d exp %0d", rd_count, STATS ? 8 : 0); else passed++;
   endtask

   task automatic test_backpressure();
      int nrd = 0;
      do_reset();
      load_words(16'h0001, 8);
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) @(negedge clk);
         enable = 1'b1; m_if.m_ready = (c >= 8);
         #1;
         if (c <= 7 && fifo_rd_en === 1'b1) nrd++;
         if (c >= 3 && c <= 7) begin
            total++; if (m_if.m_valid !== 1'b1 || m_if.m_data !== 16'h0001) $display("FAIL bp_hold c=%0d got v=%b d=%h exp v=1 d=0001", c, m_if.m_valid, m_if.m_data); else passed++;
         end
         if (c >= 8) begin
            total++; if (m_if.m_valid !== 1'b1 || m_if.m_data !== 16'(c - 7)) $display("FAIL bp_order c=%0d got v=%b d=%h exp v=1 d=%h", c, m_if.m_valid, m_if.m_data, 16'(c - 7)); else passed++;
         end
      end
      total++; if (nrd != 2) $display("FAIL bp_reads got %0d exp 2", nrd); else passed++;
   endtask

   task automatic test_drain();
      logic exp_busy;
      do_reset();
      load_words(16'h0010, 4);
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) @(negedge clk);
         m_if.m_ready = 1'b1;
         enable = (c == 0);
         #1;
         if (c == 1) begin
            total++; if (fifo_rd_en !== 1'b1) $display("FAIL drain_first_rd got %b exp 1", fifo_rd_en); else passed++;
         end
         if (c >= 2) begin
            total++; if (fifo_rd_en !== 1'b0) $display("FAIL drain_rd_en c=%0d got %b exp 0", c, fifo_rd_en); else passed++;
            total++; if (m_if.m_valid !== (c == 3)) $display("FAIL drain_valid c=%0d got %b exp %b", c, m_if.m_valid, (c == 3)); else passed++;
            exp_busy = (c <= 4);
            total++; if (busy !== exp_busy) $display("FAIL drain_busy c=%0d got %b exp %b", c, busy, exp_busy); else passed++;
         end
         if (c == 3) begin
            total++; if (m_if.m_data !== 16'h0010) $display("FAIL drain_data got %h exp 0010", m_if.m_data); else passed++;
         end
      end
      total++; if (rd_count !== (STATS ? 16'd1 : 16'd0)) $display("FAIL drain_rd_count got %0d exp %0d", rd_count, STATS ? 1 : 0); else passed++;
   endtask

   task automatic test_underflow();
      do_reset();
      load_words(16'h00A1, 2);
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) @(negedge clk);
         enable = 1'b1; m_if.m_ready = 1'b1;
         force_uf = (c <= 1);
         #1;
         if (c == 3) begin
            total++; if (m_if.m_valid !== 1'b0) $display("FAIL uf_discard got %b exp 0", m_if.m_valid); else passed++;
         end
         if (c == 4) begin
            total++; if (m_if.m_valid !== 1'b1 || m_if.m_data !== 16'h00A2) $display("FAIL uf_next got v=%b d=%h exp v=1 d=00a2", m_if.m_valid, m_if.m_data); else passed++;
         end
      end
      total++; if (err_underflow !== STATS) $display("FAIL uf_err got %b exp %b", err_underflow, STATS); else passed++;
      total++; if (uf_count !== (STATS ? 8'd1 : 8'd0)) $display("FAIL uf_count got %0d exp %0d", uf_count, STATS ? 1 : 0); else passed++;
   endtask

   task automatic test_uf_saturate();
      int nvalid = 0;
      do_reset();
      load_words(16'h1000, 300);
      for (int c = 0; c <= 280; c++) begin
         if (c > 0) @(negedge clk);
         enable = 1'b1; m_if.m_ready = 1'b1; force_uf = 1'b1;
         #1;
         if (m_if.m_valid === 1'b1) nvalid++;
      end
      force_uf = 1'b0;
      total++; if (nvalid != 0) $display("FAIL sat_valid got %0d exp 0", nvalid); else passed++;
      total++; if (uf_count !== (STATS ? 8'd255 : 8'd0)) $display("FAIL sat_uf_count got %0d exp %0d", uf_count, STATS ? 255 : 0); else passed++;
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      do_reset();
      load_words(16'h0001, 8);
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) @(negedge clk);
         enable = 1'b1; m_if.m_ready = 1'b0;
         #1;
      end
      total++; if (m_if.m_valid !== 1'b1) $display("FAIL mid_prefill got %b exp 1", m_if.m_valid); else passed++;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (m_if.m_valid !== 1'b0 || m_if.m_data !== 16'h0) $display("FAIL mid_async got v=%b d=%h exp v=0 d=0000", m_if.m_valid, m_if.m_data); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else passed++;
      @(negedge clk);
      rst_n = 1'b1; enable = 1'b1; m_if.m_ready = 1'b1;
      @(negedge clk);
      #1;
      total++; if (m_if.m_valid !== 1'b0) $display("FAIL mid_first_cycle got %b exp 0", m_if.m_valid); else passed++;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         #1;
         if (m_if.m_valid === 1'b1) begin
            seen = 1'b1;
            total++; if (m_if.m_data !== 16'h0003) $display("FAIL mid_next_word got %h exp 0003", m_if.m_data); else passed++;
         end
      end
      if (!seen) begin
         total++;
         $display("FAIL mid_timeout got no m_valid exp m_valid within 10 cycles");
      end
   endtask

   task automatic test_stats_clr();
      int ndel = 0;
      do_reset();
      load_words(16'h0100, 301);
      for (int c = 0; c < 400 && ndel < 300; c++) begin
         if (c > 0) @(negedge clk);
         enable = 1'b1; m_if.m_ready = 1'b1;
         force_uf = (c <= 1);
         #1;
         if (m_if.m_valid === 1'b1) begin
            if (ndel == 0) begin
               total++; if (m_if.m_data !== 16'h0101) $display("FAIL clr_first got %h exp 0101", m_if.m_data); else passed++;
            end
            ndel++;
         end
      end
      total++; if (ndel != 300) $display("FAIL clr_delivered got %0d exp 300", ndel); else passed++;
      repeat (3) @(negedge clk);
      #1;
      total++; if (rd_count !== (STATS ? 16'd300 : 16'd0)) $display("FAIL clr_rd_before got %0d exp %0d", rd_count, STATS ? 300 : 0); else passed++;
      total++; if (err_underflow !== STATS) $display("FAIL clr_err_before got %b exp %b", err_underflow, STATS); else passed++;
      @(negedge clk);
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      #1;
      total++; if (rd_count !== 16'd0) $display("FAIL clr_rd_after got %0d exp 0", rd_count); else passed++;
      total++; if (err_underflow !== 1'b0) $display("FAIL clr_err_after got %b exp 0", err_underflow); else passed++;
      total++; if (uf_count !== 8'd0) $display("FAIL clr_uf_after got %0d exp 0", uf_count); else passed++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_drain();
      test_underflow();
      test_uf_saturate();
      test_reset_mid();
      test_stats_clr();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter FIFO_WIDTH, 16, data word width in bits.
REQ-002 Parameter FIFO_DEPTH, 8, depth of attached FIFO; used only to size nothing beyond documentation checks (>=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  level; 1 = drain FIFO to stream port.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 fifo_underflow  input  1  FIFO underflow flag, valid the cycle after fifo_rd_en.
REQ-009 fifo_rd_en  output  1  FIFO read enable (one pop per high cycle).
REQ-010 m_data  output  FIFO_WIDTH  stream data.
REQ-011 m_valid  output  1  stream data valid.
REQ-012 m_ready  input  1  stream sink ready; transfer when m_valid && m_ready.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 err_underflow  output  1  sticky underflow error.
REQ-015 stats_clr  input  1  synchronous clear of statistics counters.
REQ-016 rd_count  output  16  words delivered on stream port.
REQ-017 uf_count  output  8  underflow events observed.

Function
REQ-018 Output buffer SHALL be a 2-entry FIFO (skid); m_valid = occupancy>0, m_data = head entry; data SHALL be held stable while m_valid && !m_ready.
REQ-019 inflight SHALL be 1 in the cycle after fifo_rd_en=1, else 0.
REQ-020 fifo_rd_en SHALL be 1 iff state==RUN && !fifo_empty && (occupancy + inflight - pop) < 2, pop = m_valid && m_ready.
REQ-021 Read latency: fifo_rd_en at cycle N -> word pushed into buffer at end of cycle N+1 -> m_valid earliest cycle N+2.
REQ-022 With m_ready held 1 and FIFO non-empty, throughput SHALL be one word per cycle after a 2-cycle fill latency.
REQ-023 If fifo_underflow=1 while inflight=1, the word SHALL be discarded (not pushed), err_underflow set, uf_count incremented.
REQ-024 States: IDLE, RUN, DRAIN.
REQ-025 IDLE -> RUN when enable=1; RUN -> DRAIN when enable=0; DRAIN -> RUN when enable=1; DRAIN -> IDLE when enable=0, inflight=0 and occupancy=0.
REQ-026 In DRAIN no new reads SHALL issue; in-flight and buffered words SHALL still be delivered.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged with correct ordering; buffer SHALL never overflow.
REQ-028 rd_count SHALL increment per stream transfer, wrapping at 2^16; uf_count SHALL saturate at 255.
REQ-029 stats_clr SHALL zero rd_count, uf_count and err_underflow; a same-cycle increment is lost (clear wins).

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=IDLE, occupancy=0, inflight=0, fifo_rd_en=0, m_valid=0, m_data=0, busy=0, err_underflow=0, rd_count=0, uf_count=0.
REQ-031 Reset mid-operation SHALL drop buffered and in-flight words; no output transfer in the first cycle after release.

Configuration
REQ-032 Macro FIFO_RD_CTRL_STATS_EN: defined -> rd_count, uf_count, err_underflow implemented per REQ-023/028/029.
REQ-033 Undefined -> those outputs tied 0, stats_clr ignored, underflowed words still discarded; ports remain present.

Verification
REQ-034 FIFO holds 0x0001..0x0008, enable=1, m_ready=1 -> fifo_rd_en first at cycle 1, m_data 0x0001..0x0008 on 8 consecutive cycles, rd_count=8.
REQ-035 m_ready=0 for 5 cycles with FIFO full -> exactly 2 reads issued, m_data stays 0x0001; on m_ready=1 order 0x0001,0x0002,0x0003 preserved.
REQ-036 enable dropped the cycle after a read -> state DRAIN, in-flight word delivered, then IDLE, busy=0, no further fifo_rd_en.
REQ-037 Force fifo_underflow=1 on cycle after a read -> word not delivered, err_underflow=1, uf_count=1 (macro defined) / both 0 (undefined).
REQ-038 rst_n low while 2 words buffered -> m_valid=0 immediately; after release with enable=1, next delivered word is next FIFO word.
REQ-039 stats_clr pulse after 300 transfers -> rd_count=0, err_underflow=0 next cycle.
